// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: redirect/stall controls, instruction memory
// handshake and the delivered instruction stream.
`ifndef WORD
`define WORD 32
`endif

interface fetch_controller_if #(
  parameter int WORD = `WORD
) ();

  logic            stall;
  logic            branch_taken;
  logic [WORD-1:0] branch_target;
  logic            imem_ack;
  logic [WORD-1:0] imem_rdata;
  logic            imem_req;
  logic [WORD-1:0] imem_addr;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] instr;
  logic            instr_valid;
  logic            fetch_err;

  // Controller side: issues fetches, delivers instructions downstream.
  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_ack,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output pc,
    output instr,
    output instr_valid,
    output fetch_err
  );

  // Environment side: instruction memory plus downstream pipeline.
  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_ack,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  pc,
    input  instr,
    input  instr_valid,
    input  fetch_err
  );

endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding fetch at a time, holds the
// delivered instruction under stall, redirects on branch, retries on timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | just out of reset, outputs quiet, moves to FETCH next edge
// FETCH   | imem_req high at pc, waiting for imem_ack, counting wait cycles
// DELIVER | instr valid for pc, held until downstream accepts or branch
`ifndef WORD
`define WORD 32
`endif

module fetch_controller #(
  parameter int              WORD     = `WORD,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  fetch_controller_if.master bus
);

  // A TIMEOUT of 0 would give a zero-width counter; keep at least one bit.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   WAIT_LIMIT = CW'(TIMEOUT);
  localparam logic [WORD-1:0] ALIGN_MASK = {{(WORD-2){1'b1}}, 2'b00};
  localparam logic [WORD-1:0] PC_STEP    = WORD'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WORD-1:0] pc_reg, pc_next;
  logic [WORD-1:0] instr_reg, instr_next;
  logic [CW-1:0]   wait_cnt, wait_cnt_next;
  logic            err_reg, err_next;
  logic [WORD-1:0] target_aligned;

  assign target_aligned = bus.branch_target & ALIGN_MASK;

  // State and datapath registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      wait_cnt  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      wait_cnt  <= wait_cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic; the wait counter and error pulse default to cleared so
  // they only survive while a fetch is actually waiting.
  always_comb begin
    state_next    = state;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    wait_cnt_next = '0;
    err_next      = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (bus.branch_taken) begin
          // Redirect wins over a same-cycle ack; that data belongs to the old pc.
          pc_next = target_aligned;
        end else if (bus.imem_ack) begin
          instr_next = bus.imem_rdata;
          state_next = DELIVER;
        end else if (wait_cnt == WAIT_LIMIT) begin
          // Give up on this attempt, flag it and retry the same address.
          err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      DELIVER: begin
        if (bus.branch_taken) begin
          pc_next    = target_aligned;
          state_next = FETCH;
        end else if (!bus.stall) begin
          pc_next    = pc_reg + PC_STEP;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.instr_valid = (state == DELIVER);
  assign bus.imem_addr   = pc_reg;
  assign bus.pc          = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.fetch_err   = err_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: scoreboard of delivered instructions plus
// directed checks on stall, branch, timeout, pc wrap and async reset.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic reset;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_pc;
  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;

  fetch_controller_if #(.WORD(32)) fa ();
  fetch_controller_if #(.WORD(32)) fb ();

  fetch_controller #(
    .WORD(32), .RESET_PC(32'h0000_0000), .TIMEOUT(15)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(fa)
  );

  fetch_controller #(
    .WORD(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(15)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(fb)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ack in a FETCH cycle and record what should be delivered.
  task automatic fetch_ack(input logic [31:0] rdata);
    check_val("fetch_req", fa.imem_req, 32'd1);
    check_val("fetch_addr", fa.imem_addr, exp_pc);
    check_val("fetch_valid", fa.instr_valid, 32'd0);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = rdata;
    sb_q.push_back({exp_pc, rdata});
    tick();
    fa.imem_ack   = 1'b0;
    fa.imem_rdata = '0;
  endtask

  // Accept the delivered instruction; pc advances by one word.
  task automatic deliver_go();
    check_val("deliver_valid", fa.instr_valid, 32'd1);
    check_val("deliver_req", fa.imem_req, 32'd0);
    fa.stall = 1'b0;
    tick();
    exp_pc = exp_pc + 32'd4;
    check_val("next_valid", fa.instr_valid, 32'd0);
    check_val("next_pc", fa.pc, exp_pc);
  endtask

  // Scoreboard: each rising instr_valid consumes one expected delivery.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (fa.instr_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", sb_q.size(), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_pc", fa.pc, e[63:32]);
          check_val("sb_instr", fa.instr, e[31:0]);
        end
      end
      prev_valid = fa.instr_valid;
    end
  end

  initial begin
    reset            = 1'b1;
    fa.stall         = 1'b1;
    fa.branch_taken  = 1'b1;
    fa.branch_target = 32'h0000_1234;
    fa.imem_ack      = 1'b1;
    fa.imem_rdata    = 32'hAAAA_5555;
    fb.stall         = 1'b0;
    fb.branch_taken  = 1'b0;
    fb.branch_target = '0;
    fb.imem_ack      = 1'b0;
    fb.imem_rdata    = '0;

    // Outputs pinned to reset values while reset is held, whatever the inputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_pc", fa.pc, 32'h0);
      check_val("rst_addr", fa.imem_addr, 32'h0);
      check_val("rst_req", fa.imem_req, 32'd0);
      check_val("rst_valid", fa.instr_valid, 32'd0);
      check_val("rst_instr", fa.instr, 32'h0);
      check_val("rst_err", fa.fetch_err, 32'd0);
    end

    fa.stall        = 1'b0;
    fa.branch_taken = 1'b0;
    fa.imem_ack     = 1'b0;
    fa.imem_rdata   = '0;
    reset = 1'b0;
    #1;
    check_val("idle_req", fa.imem_req, 32'd0);
    tick();
    exp_pc = 32'h0;

    // Back-to-back fetches with instr = pc + 0x100.
    for (int i = 0; i < 2; i++) begin
      fetch_ack(exp_pc + 32'h100);
      deliver_go();
    end

    // Stall at pc=8 for five cycles; a stray ack must not disturb instr.
    fetch_ack(32'h108);
    fa.stall      = 1'b1;
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_valid", fa.instr_valid, 32'd1);
      check_val("stall_pc", fa.pc, 32'h8);
      check_val("stall_instr", fa.instr, 32'h108);
    end
    fa.imem_ack   = 1'b0;
    fa.imem_rdata = '0;
    fa.stall      = 1'b0;
    tick();
    check_val("unstall_pc", fa.pc, 32'hC);
    check_val("unstall_req", fa.imem_req, 32'd1);
    check_val("unstall_valid", fa.instr_valid, 32'd0);
    exp_pc = 32'hC;

    // Branch overrides stall in DELIVER; low target bits dropped.
    fetch_ack(32'h10C);
    fa.stall = 1'b1;
    tick();
    check_val("pre_br_pc", fa.pc, 32'hC);
    fa.branch_taken  = 1'b1;
    fa.branch_target = 32'h0000_0403;
    tick();
    fa.branch_taken = 1'b0;
    fa.stall        = 1'b0;
    check_val("br_pc", fa.pc, 32'h400);
    check_val("br_addr", fa.imem_addr, 32'h400);
    check_val("br_req", fa.imem_req, 32'd1);
    check_val("br_valid", fa.instr_valid, 32'd0);

    // Branch in FETCH discards a same-cycle ack and stays fetching.
    fa.imem_ack      = 1'b1;
    fa.imem_rdata    = 32'hBAD0_BAD0;
    fa.branch_taken  = 1'b1;
    fa.branch_target = 32'h0000_0801;
    tick();
    fa.imem_ack     = 1'b0;
    fa.branch_taken = 1'b0;
    check_val("fbr_pc", fa.pc, 32'h800);
    check_val("fbr_req", fa.imem_req, 32'd1);
    check_val("fbr_valid", fa.instr_valid, 32'd0);
    exp_pc = 32'h800;
    fetch_ack(32'h900);
    deliver_go();

    // No ack for 17 cycles: exactly one error pulse after the 16th.
    for (int i = 1; i <= 17; i++) begin
      tick();
      check_val("tmo_err", fa.fetch_err, (i == 16) ? 32'd1 : 32'd0);
      check_val("tmo_addr", fa.imem_addr, 32'h804);
      check_val("tmo_req", fa.imem_req, 32'd1);
    end
    fetch_ack(32'h904);
    deliver_go();

    // Async reset mid-FETCH, with an ack still pending across release.
    #2;
    reset         = 1'b1;
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'h100;
    #1;
    check_val("arst_pc", fa.pc, 32'h0);
    check_val("arst_addr", fa.imem_addr, 32'h0);
    check_val("arst_req", fa.imem_req, 32'd0);
    check_val("arst_instr", fa.instr, 32'h0);
    check_val("arst_valid", fa.instr_valid, 32'd0);
    check_val("arst_b_pc", fb.pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check_val("arst_hold_req", fa.imem_req, 32'd0);
    #3;
    reset         = 1'b0;
    fb.imem_ack   = 1'b1;
    fb.imem_rdata = 32'h5A5A_5A5A;
    #1;
    check_val("rel_idle_req", fa.imem_req, 32'd0);
    tick();
    exp_pc = 32'h0;
    check_val("rel_fetch_req", fa.imem_req, 32'd1);
    check_val("rel_fetch_pc", fa.pc, 32'h0);
    check_val("rel_fetch_valid", fa.instr_valid, 32'd0);
    check_val("wrap_fetch_addr", fb.imem_addr, 32'hFFFF_FFFC);
    sb_q.push_back({exp_pc, 32'h100});
    tick();
    fa.imem_ack = 1'b0;
    fb.imem_ack = 1'b0;
    check_val("wrap_valid", fb.instr_valid, 32'd1);
    check_val("wrap_instr", fb.instr, 32'h5A5A_5A5A);
    tick();
    check_val("wrap_pc", fb.pc, 32'h0);
    check_val("wrap_req", fb.imem_req, 32'd1);
    check_val("after_rel_pc", fa.pc, 32'h4);

    tick();
    check_val("sb_drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
